// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// for a 16-line x 4-word data RAM. Owns the tag/valid arrays, serves single
// word loads/stores from the core, refills lines from memory in four word
// beats and forwards every store to memory.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   core_req/write/addr/...   core LSU request (held until core_stall = 0)
//   core_stall, core_rdata    completion handshake and load data
//   mem_req/write/addr/...    memory bus request, accepted on mem_ready
//   mem_rvalid, mem_rdata     refill beats (4 per line, word 0 first)
//   dr_wen/index/datain/strb  data RAM write port and line select
//   dr_dataout                data RAM combinational line read
//   hit_cnt, miss_cnt         saturating load hit / load miss counters
module cache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic                core_write,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [31:0]         core_wdata,
    input  logic [3:0]          core_wstrb,
    output logic                core_stall,
    output logic [31:0]         core_rdata,
    output logic                mem_req,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [31:0]         mem_rdata,
    output logic                dr_wen,
    output logic [INDEX_W-1:0]  dr_index,
    output logic [127:0]        dr_datain,
    output logic [15:0]         dr_strb,
    input  logic [127:0]        dr_dataout,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    localparam int NLINES = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, MISS_REQ, FILL, REFILL, WR_MEM} state_t;

    state_t                 state;
    logic [NLINES-1:0]      valid;
    logic [TAG_W-1:0]       tagArr [NLINES];
    logic [1:0]             beat;
    logic [3:0][31:0]       fillBuf;
    logic                   replay;

    // Request fields latched when leaving IDLE
    logic [TAG_W-1:0]       latTag;
    logic [INDEX_W-1:0]     latIdx;
    logic [1:0]             latWord;
    logic [31:0]            latWdata;
    logic [3:0]             latWstrb;

    logic [TAG_W-1:0]       curTag;
    logic [INDEX_W-1:0]     curIdx;
    logic [1:0]             curWord;
    logic                   hit;
    logic                   loadHit;
    logic                   storeHit;
    logic                   leaveIdle;
    logic                   unusedBits;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign curTag     = core_addr[ADDR_W-1:INDEX_W+4];
    assign curIdx     = core_addr[INDEX_W+3:4];
    assign curWord    = core_addr[3:2];
    // Byte offset is irrelevant: accesses are whole words with strobes
    assign unusedBits = ^core_addr[1:0];

    assign hit       = valid[curIdx] && (tagArr[curIdx] == curTag);
    assign loadHit   = (state == IDLE) && core_req && !core_write && hit;
    assign storeHit  = (state == IDLE) && core_req && core_write && hit;
    assign leaveIdle = (state == IDLE) && core_req && (core_write || !hit);

    // Core side: load hits finish in the cycle they are presented; a store
    // completes in the cycle memory accepts it.
    always_comb begin
        core_stall = 1'b1;
        case (state)
            IDLE:    core_stall = core_req && !(!core_write && hit);
            WR_MEM:  core_stall = !mem_ready;
            default: core_stall = 1'b1;
        endcase
    end

    assign core_rdata = loadHit ? dr_dataout[{curWord, 5'd0} +: 32] : 32'd0;

    // Memory side is decoded from the registered state and latched fields only
    assign mem_req   = (state == MISS_REQ) || (state == WR_MEM);
    assign mem_write = (state == WR_MEM);
    always_comb begin
        mem_addr = '0;
        if (state == MISS_REQ)
            mem_addr = {latTag, latIdx, 4'b0000};
        else if (state == WR_MEM)
            mem_addr = {latTag, latIdx, latWord, 2'b00};
    end
    assign mem_wdata = (state == WR_MEM) ? latWdata : 32'd0;
    assign mem_wstrb = (state == WR_MEM) ? latWstrb : 4'd0;

    // Data RAM port: store hits patch one word in place, refills write the line
    assign dr_wen    = storeHit || (state == REFILL);
    assign dr_index  = ((state == FILL) || (state == REFILL)) ? latIdx : curIdx;
    assign dr_datain = (state == REFILL) ? fillBuf : {4{core_wdata}};
    always_comb begin
        dr_strb = 16'h0000;
        if (state == REFILL)
            dr_strb = 16'hFFFF;
        else if (storeHit)
            dr_strb = 16'(core_wstrb) << {curWord, 2'b00};
    end

    // Control state, valid bits, fill buffer and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= '0;
            beat     <= 2'd0;
            fillBuf  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            replay   <= 1'b0;
        end else begin
            replay <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req) begin
                        if (core_write) begin
                            state <= WR_MEM;
                        end else if (hit) begin
                            // The hit that replays a just-refilled miss was
                            // already counted as a miss.
                            if (!replay)
                                hit_cnt <= satInc(hit_cnt);
                        end else begin
                            miss_cnt <= satInc(miss_cnt);
                            state    <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (mem_ready) begin
                        state <= FILL;
                        beat  <= 2'd0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        fillBuf[beat] <= mem_rdata;
                        beat          <= beat + 2'd1;
                        if (beat == 2'd3)
                            state <= REFILL;
                    end
                end
                REFILL: begin
                    valid[latIdx] <= 1'b1;
                    replay        <= 1'b1;
                    state         <= IDLE;
                end
                WR_MEM: begin
                    if (mem_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag array and latched request fields carry data only
    always_ff @(posedge clk) begin
        if (leaveIdle) begin
            latTag   <= curTag;
            latIdx   <= curIdx;
            latWord  <= curWord;
            latWdata <= core_wdata;
            latWstrb <= core_wstrb;
        end
        if (state == REFILL)
            tagArr[latIdx] <= latTag;
    end

endmodule
